fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch/execute controller for the 8-bit CPU core. It owns the program counter and the instruction register, and reads program memory over a request/acknowledge handshake. It presents the latched instruction to the instruction decoder and issues a one-cycle execute strobe that gates register-file and status-register writes. It resolves GOTO and the conditional-skip opcodes (IFZ, IFNZ, IFEQ, IFST, IFGT) against the status register.

## Interface
Parameters:
- PC_WIDTH, 8, program counter and program address width
- PROGRAM_DataWidth, 16, instruction word width
- NumStatusBits, 3, status register width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset, fixed for this block
- run  in  1  level; while high, instructions are fetched and executed back-to-back
- prog_rd_en  out  1  program memory read request
- prog_addr  out  PC_WIDTH  read address; always equals pc
- prog_ack  in  1  memory acknowledge; prog_data valid in the same cycle
- prog_data  in  PROGRAM_DataWidth  instruction word from memory
- instr  out  PROGRAM_DataWidth  instruction register to decoder; opcode is instr[15:11], literal is instr[7:0]
- status  in  NumStatusBits  status register: bit0 = Z (zero), bit1 = C (borrow/carry), bit2 unused
- exec_en  out  1  one-cycle strobe; datapath commits decoder-requested writes only when high
- pc  out  PC_WIDTH  current program counter
- halted  out  1  high after HALT (opcode 5'b1_1111) executes

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: prog_rd_en=0, exec_en=0. Moves to FETCH when run=1.
- FETCH: prog_rd_en=1 and prog_addr=pc, held until prog_ack=1. On the ack cycle, ir <= prog_data and the state moves to EXEC. run is not sampled in FETCH, so a started fetch always completes.
- EXEC: exec_en=1 for exactly this cycle. status is sampled in this cycle and pc is updated at the end of it. Next pc by opcode:
  - GOTO (1_0000): pc <= instr[7:0], truncated or zero-extended to PC_WIDTH.
  - IFZ (1_0001): condition Z.
  - IFNZ (1_0010): condition !Z.
  - IFEQ (1_0011): condition Z.
  - IFST (1_0100): condition C.
  - IFGT (1_0101): condition !Z & !C.
  - For all IF opcodes: if the condition is true, pc <= pc+1 (the next instruction executes); if false, pc <= pc+2 (the next instruction is skipped).
  - HALT (1_1111): pc unchanged; state moves to HALT.
  - All other opcodes, including reserved ones: pc <= pc+1.
- After EXEC, the state moves to FETCH if run=1, otherwise to IDLE.
- All pc arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 = 8'h00 and 8'hFF+2 = 8'h01.
- HALT: halted=1, no fetches. The only exit is reset.

## Timing
- Reset values: state=IDLE, pc=0, ir=16'h0000 (NOP), prog_rd_en=0, exec_en=0, halted=0.
- Reset asserted mid-FETCH or mid-EXEC: the next edge aborts the operation, and no exec_en is issued afterward. An outstanding prog_ack after reset is ignored.
- Reset has priority over run. If reset and run are high together, the block is in IDLE after the edge.
- prog_ack in the first FETCH cycle is legal (zero-wait memory). Throughput is then 2 cycles per instruction.
- Each wait cycle without ack extends FETCH by one cycle.
- prog_ack while prog_rd_en=0 is ignored.
- instr is stable from the edge that latches it until the next ack, so decoder outputs are valid throughout EXEC.
- Dropping run in EXEC lets the current instruction complete; the block enters IDLE on the next edge.

## Configuration
- FETCH_SEQ_STEP_EN defined:
  - Adds input `step` (1 bit).
  - In IDLE with run=0, a cycle with step=1 executes exactly one instruction (FETCH then EXEC) and returns to IDLE.
  - step is ignored outside IDLE.
- FETCH_SEQ_STEP_EN undefined: no step port, and only run starts execution.

## Test plan
- Reset, then run=1 with zero-wait memory holding NOP at 0..3 -> prog_addr 0,1,2,3 at cycles 1,3,5,7 after run; exec_en high on alternate cycles.
- GOTO 8'h40 at address 5 -> after its EXEC, pc=8'h40 and the next prog_addr=8'h40; no fetch from 6.
- IFZ at address 10 with status=3'b001 -> next fetch at 11. Same with status=3'b000 -> next fetch at 12. IFGT with status=3'b000 -> next fetch at 11.
- Memory acks 3 cycles late at address 8'hFF (NOP) -> prog_rd_en high 4 cycles, one exec_en, pc wraps to 8'h00. IFNZ false at 8'hFF -> pc=8'h01.
- Reset asserted during the FETCH wait at pc=7 -> pc=0, prog_rd_en=0 next cycle, no exec_en even if prog_ack arrives.
- HALT at address 3 -> halted=1, no further prog_rd_en with run=1 held for 20 cycles; reset clears halted.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute controller owning the pc and instruction register.
// Define FETCH_SEQ_STEP_EN to add the single-step input.
module fetch_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumStatusBits     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
`ifdef FETCH_SEQ_STEP_EN
    input  logic                         step,
`endif
    output logic                         prog_rd_en,
    output logic [PC_WIDTH-1:0]          prog_addr,
    input  logic                         prog_ack,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    output logic [PROGRAM_DataWidth-1:0] instr,
    input  logic [NumStatusBits-1:0]     status,
    output logic                         exec_en,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_GOTO = 5'b1_0000;
    localparam logic [4:0] OP_IFZ  = 5'b1_0001;
    localparam logic [4:0] OP_IFNZ = 5'b1_0010;
    localparam logic [4:0] OP_IFEQ = 5'b1_0011;
    localparam logic [4:0] OP_IFST = 5'b1_0100;
    localparam logic [4:0] OP_IFGT = 5'b1_0101;
    localparam logic [4:0] OP_HALT = 5'b1_1111;

    state_t                         state;
    state_t                         state_next;
    logic [PC_WIDTH-1:0]            pc_next;
    logic [PC_WIDTH-1:0]            goto_target;
    logic [PROGRAM_DataWidth-1:0]   ir;
    logic                           ir_load;
    logic [4:0]                     opcode;
    logic                           flag_z;
    logic                           flag_c;
    logic                           is_skip_op;
    logic                           skip_cond;
    logic                           single_step;
    logic                           status_unused;

    assign opcode        = ir[15:11];
    assign flag_z        = status[0];
    assign flag_c        = status[1];
    assign status_unused = ^status;

    // The 8-bit literal is narrowed or zero-extended to the pc width.
    generate
        if (PC_WIDTH <= 8) begin : g_goto_trunc
            assign goto_target = ir[PC_WIDTH-1:0];
        end else begin : g_goto_ext
            assign goto_target = {{(PC_WIDTH-8){1'b0}}, ir[7:0]};
        end
    endgenerate

`ifdef FETCH_SEQ_STEP_EN
    // Remembers that the current fetch/exec pair was started by step, not run.
    always_ff @(posedge clk) begin
        if (reset) begin
            single_step <= 1'b0;
        end else if (state == ST_IDLE) begin
            single_step <= !run && step;
        end else if (state == ST_EXEC) begin
            single_step <= 1'b0;
        end
    end
`else
    assign single_step = 1'b0;
`endif

    always_comb begin
        is_skip_op = 1'b1;
        skip_cond  = 1'b0;
        case (opcode)
            OP_IFZ, OP_IFEQ: skip_cond = flag_z;
            OP_IFNZ:         skip_cond = !flag_z;
            OP_IFST:         skip_cond = flag_c;
            OP_IFGT:         skip_cond = !flag_z && !flag_c;
            default:         is_skip_op = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        prog_rd_en = 1'b0;
        exec_en    = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef FETCH_SEQ_STEP_EN
                if (run || step) state_next = ST_FETCH;
`else
                if (run) state_next = ST_FETCH;
`endif
            end
            ST_FETCH: begin
                prog_rd_en = 1'b1;
                if (prog_ack) begin
                    ir_load    = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                if (opcode == OP_GOTO) begin
                    pc_next = goto_target;
                end else if (opcode == OP_HALT) begin
                    pc_next = pc;
                end else if (is_skip_op && !skip_cond) begin
                    pc_next = pc + PC_WIDTH'(2);
                end else begin
                    pc_next = pc + PC_WIDTH'(1);
                end
                if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else if (run && !single_step) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) ir <= prog_data;
        end
    end

    assign prog_addr = pc;
    assign instr     = ir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized bench for fetch_sequencer against an instruction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        prog_rd_en;
    logic [7:0]  prog_addr;
    logic        prog_ack;
    logic [15:0] prog_data;
    logic [15:0] instr;
    logic [2:0]  status;
    logic        exec_en;
    logic [7:0]  pc;
    logic        halted;
`ifdef FETCH_SEQ_STEP_EN
    logic        step = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PC_WIDTH(8),
        .PROGRAM_DataWidth(16),
        .NumStatusBits(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
`ifdef FETCH_SEQ_STEP_EN
        .step(step),
`endif
        .prog_rd_en(prog_rd_en),
        .prog_addr(prog_addr),
        .prog_ack(prog_ack),
        .prog_data(prog_data),
        .instr(instr),
        .status(status),
        .exec_en(exec_en),
        .pc(pc),
        .halted(halted)
    );

    typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT} mphase_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] mem [256];

    mphase_t     m_phase;
    int          m_pc;
    logic [15:0] m_ir;
    int          wait_left;

    bit          k_run_random;
    bit          k_status_random;
    logic [2:0]  k_status_val;
    bit          k_wait_random;
    int          k_wait_max;
    int          k_reset_pct;
    bit          k_spurious;
    bit          force_reset;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int pickWait();
        return k_wait_random ? int'($urandom_range(0, k_wait_max)) : k_wait_max;
    endfunction

    task automatic checkAll();
        checkOutput("prog_rd_en", prog_rd_en, m_phase == M_FETCH);
        checkOutput("exec_en", exec_en, m_phase == M_EXEC);
        checkOutput("halted", halted, m_phase == M_HALT);
        checkOutput("pc", pc, m_pc[7:0]);
        if (m_phase == M_FETCH) checkOutput("prog_addr", prog_addr, m_pc[7:0]);
        if (m_phase == M_EXEC) checkOutput("instr", instr, m_ir);
    endtask

    // Drives one cycle of inputs, advances the model by one cycle, then waits past the edge.
    task automatic applyStimulus();
        bit         do_reset;
        bit         cond;
        bit         is_if;
        logic [4:0] op;
        do_reset  = force_reset || ($urandom_range(0, 99) < k_reset_pct);
        run       = k_run_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        status    = k_status_random ? 3'($urandom) : k_status_val;
        prog_ack  = 1'b0;
        prog_data = 16'($urandom);
        if (m_phase == M_FETCH) begin
            if (wait_left == 0) begin
                prog_ack  = 1'b1;
                prog_data = mem[prog_addr];
            end else begin
                wait_left--;
            end
        end else if (k_spurious && $urandom_range(0, 3) == 0) begin
            prog_ack = 1'b1;
        end
        reset = do_reset;

        if (do_reset) begin
            m_phase = M_IDLE;
            m_pc    = 0;
            m_ir    = 16'h0000;
        end else begin
            case (m_phase)
                M_IDLE: if (run) begin
                    m_phase   = M_FETCH;
                    wait_left = pickWait();
                end
                M_FETCH: if (prog_ack) begin
                    m_ir    = mem[m_pc];
                    m_phase = M_EXEC;
                end
                M_EXEC: begin
                    op    = m_ir[15:11];
                    is_if = 1'b1;
                    cond  = 1'b0;
                    case (op)
                        5'h11, 5'h13: cond = status[0];
                        5'h12:        cond = !status[0];
                        5'h14:        cond = status[1];
                        5'h15:        cond = !status[0] && !status[1];
                        default:      is_if = 1'b0;
                    endcase
                    if (op == 5'h10)      m_pc = int'(m_ir[7:0]);
                    else if (op == 5'h1F) m_pc = m_pc;
                    else if (is_if)       m_pc = (m_pc + (cond ? 1 : 2)) % 256;
                    else                  m_pc = (m_pc + 1) % 256;
                    if (op == 5'h1F) begin
                        m_phase = M_HALT;
                    end else if (run) begin
                        m_phase   = M_FETCH;
                        wait_left = pickWait();
                    end else begin
                        m_phase = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            checkAll();
            applyStimulus();
        end
    endtask

    task automatic resetCycle();
        force_reset = 1'b1;
        runCycles(1);
        force_reset = 1'b0;
    endtask

    function automatic logic [15:0] randomInstr();
        logic [4:0] op;
        int         r;
        r = $urandom_range(0, 19);
        if (r < 8)       op = 5'($urandom_range(0, 15));
        else if (r < 10) op = 5'($urandom_range(22, 30));
        else if (r < 12) op = 5'h10;
        else if (r < 19) op = 5'($urandom_range(17, 21));
        else             op = 5'h1F;
        return {op, 11'($urandom)};
    endfunction

    initial begin
        k_run_random    = 1'b0;
        k_status_random = 1'b0;
        k_status_val    = 3'b001;
        k_wait_random   = 1'b0;
        k_wait_max      = 0;
        k_reset_pct     = 0;
        k_spurious      = 1'b0;
        force_reset     = 1'b0;
        wait_left       = 0;
        reset           = 1'b1;
        run             = 1'b0;
        prog_ack        = 1'b0;
        prog_data       = 16'h0000;
        status          = 3'b000;
        m_phase         = M_IDLE;
        m_pc            = 0;
        m_ir            = 16'h0000;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        @(posedge clk);
        #1;

        // Directed program: GOTO, taken IFZ, false IFGT skip, GOTO FF, false IFNZ wrapping to 01.
        mem[8'h05] = 16'h8040;
        mem[8'h40] = 16'h8800;
        mem[8'h41] = 16'hA800;
        mem[8'h43] = 16'h80FF;
        mem[8'hFF] = 16'h9000;
        runCycles(60);
        k_status_val = 3'b000;
        runCycles(40);
        k_wait_max = 3;
        runCycles(60);
        k_spurious = 1'b1;
        k_run_random = 1'b1;
        runCycles(60);

        // HALT at address 3 must stop all fetching until reset.
        k_run_random = 1'b0;
        k_spurious   = 1'b0;
        k_wait_max   = 0;
        resetCycle();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[3] = 16'hF800;
        runCycles(30);
        resetCycle();
        checkOutput("halted_cleared", halted, 1'b0);

        // Fully randomized program, timing, status, run and resets.
        for (int a = 0; a < 256; a++) mem[a] = randomInstr();
        k_run_random    = 1'b1;
        k_status_random = 1'b1;
        k_wait_random   = 1'b1;
        k_wait_max      = 3;
        k_reset_pct     = 1;
        k_spurious      = 1'b1;
        runCycles(4000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
